// File: rtl/zx_pdm_pkg.sv
// Shared widths, default parameters and the sample-to-sign/magnitude helper
// for the multi-channel PDM DAC.
package zx_pdm_pkg;

   localparam int ZX_CHANNELS = 4;
   localparam int DAC_W       = 8;
   localparam int VOL_W       = 6;
   localparam int ZX_VOL_STEP = 31;
   localparam int ZX_RAMP_DIV = 16;

   localparam logic [DAC_W-1:0] SAMPLE_ZERO = {1'b1, {(DAC_W-1){1'b0}}};

   typedef struct packed {
      logic [DAC_W-1:0] sample;
      logic [VOL_W-1:0] vol;
   } zx_shadow_t;

   localparam int SHADOW_W = $bits(zx_shadow_t);
   localparam zx_shadow_t SHADOW_RST = '{sample: SAMPLE_ZERO, vol: {VOL_W{1'b0}}};

   // Offset binary to {sign, magnitude}; both codes adjacent to zero map to mag 0.
   function automatic logic [DAC_W-1:0] pdm_mag(input logic [DAC_W-1:0] s);
      logic [DAC_W-2:0] mag;
      if (s[DAC_W-1]) begin
         mag = s[DAC_W-2:0];
      end else begin
         mag = ~s[DAC_W-2:0];
      end
      return {s[DAC_W-1], mag};
   endfunction

endpackage

// File: rtl/zx_pdm_chan.sv
// One DAC channel: active sample/volume, slewed volume, gated first-order
// accumulator and registered pin driver.
module zx_pdm_chan
   import zx_pdm_pkg::*;
(
   input  logic                clk32,
   input  logic                rst_n,
   input  logic                upd_i,
   input  logic [SHADOW_W-1:0] shadow_i,
   input  logic [VOL_W-1:0]    vol_cnt_i,
   input  logic                mid_tgl_i,
   input  logic                ramp_tick_i,
   output logic                pdm_o
);

   zx_shadow_t       shadow_s;
   logic [DAC_W-1:0] sm_s;
   logic [DAC_W-2:0] mag_s;
   logic             sign_s;
   logic             gate_s;

   logic [DAC_W-1:0] samp_q, samp_d;
   logic [VOL_W-1:0] tgt_q, tgt_d;
   logic [VOL_W-1:0] vol_cur_q, vol_cur_d;
   logic [DAC_W-1:0] acc_q, acc_d;
   logic             pdm_q, pdm_d;

   assign shadow_s = shadow_i;
   assign sm_s     = pdm_mag(samp_q);
   assign sign_s   = sm_s[DAC_W-1];
   assign mag_s    = sm_s[DAC_W-2:0];
   // Full-scale volume bypasses the comparator so the gate is truly always on.
   assign gate_s   = (vol_cnt_i < vol_cur_q) || (&vol_cur_q);

   // Next-state: active load, volume slew, accumulator and output select.
   always_comb begin
      samp_d    = samp_q;
      tgt_d     = tgt_q;
      vol_cur_d = vol_cur_q;
      acc_d     = acc_q;
      pdm_d     = pdm_q;

      if (upd_i) begin
         samp_d = shadow_s.sample;
         tgt_d  = shadow_s.vol;
      end else begin
         samp_d = samp_q;
         tgt_d  = tgt_q;
      end

      if (ramp_tick_i && (vol_cur_q < tgt_q)) begin
         vol_cur_d = vol_cur_q + VOL_W'(1);
      end else if (ramp_tick_i && (vol_cur_q > tgt_q)) begin
         vol_cur_d = vol_cur_q - VOL_W'(1);
      end else begin
         vol_cur_d = vol_cur_q;
      end

      if (gate_s) begin
         acc_d = {1'b0, acc_q[DAC_W-2:0]} + {1'b0, mag_s};
      end else begin
         acc_d = {1'b0, acc_q[DAC_W-2:0]};
      end

      if (acc_q[DAC_W-1]) begin
         pdm_d = sign_s;
      end else begin
         pdm_d = mid_tgl_i;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         samp_q    <= SAMPLE_ZERO;
         tgt_q     <= {VOL_W{1'b0}};
         vol_cur_q <= {VOL_W{1'b0}};
         acc_q     <= {DAC_W{1'b0}};
         pdm_q     <= 1'b0;
      end else begin
         samp_q    <= samp_d;
         tgt_q     <= tgt_d;
         vol_cur_q <= vol_cur_d;
         acc_q     <= acc_d;
         pdm_q     <= pdm_d;
      end
   end

   assign pdm_o = pdm_q;

endmodule

// File: rtl/zx_pdm_dac.sv
// Multi-channel 1-bit PDM DAC: shadow bank with write decode, shared volume
// gate counter, ramp divider and half-scale toggle feeding CHANNELS modulators.
module zx_pdm_dac
   import zx_pdm_pkg::*;
#(
   parameter int CHANNELS = ZX_CHANNELS,
   parameter int VOL_STEP = ZX_VOL_STEP,
   parameter int RAMP_DIV = ZX_RAMP_DIV,
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1
) (
   input  logic                clk32,
   input  logic                rst_n,
   input  logic                wr_stb,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [DAC_W-1:0]    wr_data,
   input  logic [VOL_W-1:0]    wr_vol,
   input  logic                upd,
   output logic [CHANNELS-1:0] pdm_out
);

   localparam logic [VOL_W-1:0] VOL_INC   = VOL_W'(VOL_STEP);
   localparam logic [RC_W-1:0]  RAMP_LAST = RC_W'(RAMP_DIV - 1);

   zx_shadow_t      shadow_q [CHANNELS];
   zx_shadow_t      shadow_d [CHANNELS];
   logic [VOL_W-1:0] vol_cnt_q, vol_cnt_d;
   logic [RC_W-1:0]  ramp_cnt_q, ramp_cnt_d;
   logic             mid_tgl_q, mid_tgl_d;
   logic             ramp_tick_s;

   assign ramp_tick_s = (ramp_cnt_q == RAMP_LAST);

   // Write decode into the shadow bank plus the shared free-running counters.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_stb && (int'(wr_ch) < CHANNELS)) begin
         shadow_d[wr_ch] = '{sample: wr_data, vol: wr_vol};
      end else begin
         shadow_d = shadow_q;
      end

      vol_cnt_d = vol_cnt_q + VOL_INC;
      mid_tgl_d = ~mid_tgl_q;
      if (ramp_tick_s) begin
         ramp_cnt_d = {RC_W{1'b0}};
      end else begin
         ramp_cnt_d = ramp_cnt_q + RC_W'(1);
      end
   end

   // Shared state registers.
   always_ff @(posedge clk32 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= SHADOW_RST;
         end
         vol_cnt_q  <= {VOL_W{1'b0}};
         ramp_cnt_q <= {RC_W{1'b0}};
         mid_tgl_q  <= 1'b0;
      end else begin
         shadow_q   <= shadow_d;
         vol_cnt_q  <= vol_cnt_d;
         ramp_cnt_q <= ramp_cnt_d;
         mid_tgl_q  <= mid_tgl_d;
      end
   end

   // Channels see the registered shadow, so a same-cycle write misses that upd.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      zx_pdm_chan u_chan (
         .clk32       (clk32),
         .rst_n       (rst_n),
         .upd_i       (upd),
         .shadow_i    (shadow_q[i]),
         .vol_cnt_i   (vol_cnt_q),
         .mid_tgl_i   (mid_tgl_q),
         .ramp_tick_i (ramp_tick_s),
         .pdm_o       (pdm_out[i])
      );
   end

endmodule
